// File: rtl/block_memory_responder.sv
// Main-memory responder for a direct-mapped cache refill: returns an aligned block after a latency.
// Optional macro BLOCK_MEM_REQ_COUNT_EN adds a saturating readCount output.
`timescale 1ns/1ps
module block_memory_responder #(
   parameter int unsigned ADDR_WIDTH      = 15,
   parameter int unsigned WORD_WIDTH      = 32,
   parameter int unsigned WORDS_PER_BLOCK = 4,
   parameter int unsigned LATENCY         = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  memRead,
   input  logic [ADDR_WIDTH-1:0]                 address,
   input  logic                                  memWrite,
   input  logic [WORD_WIDTH-1:0]                 writeData,
   output logic [WORDS_PER_BLOCK*WORD_WIDTH-1:0] blockOut,
   output logic                                  blockReady,
   output logic                                  busy
`ifdef BLOCK_MEM_REQ_COUNT_EN
   ,
   output logic [13:0]                           readCount
`endif
);

   localparam int unsigned Depth = 1 << ADDR_WIDTH;
   localparam int unsigned OffW  = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
   localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [OffW-1:0]       LastOff = OffW'(WORDS_PER_BLOCK - 1);
   localparam logic [CntW-1:0]       CntLoad = CntW'((LATENCY == 0) ? 0 : LATENCY - 1);
   localparam logic [ADDR_WIDTH-1:0] BlkMask = ADDR_WIDTH'(WORDS_PER_BLOCK - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StWait  = 2'd1;
   localparam logic [1:0] StFetch = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [OffW-1:0]       off_q, off_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH-1:0] fetch_addr;
   logic [WORD_WIDTH-1:0] rd_word;

   logic [WORDS_PER_BLOCK-1:0][WORD_WIDTH-1:0] block_q;

   logic [WORD_WIDTH-1:0] mem [Depth];

   // Offset is OR-ed into an aligned base, so a fetch can never leave its block.
   assign fetch_addr = base_q | ADDR_WIDTH'(off_q);
   assign rd_word    = mem[fetch_addr];

   // Memory contents survive reset; writes only land while idle.
   always_ff @(posedge clk) begin
      if (state_q == StIdle && memWrite) begin
         mem[address] <= writeData;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      off_d   = off_q;
      base_d  = base_q;
      case (state_q)
         StIdle: begin
            if (memRead) begin
               base_d = address & ~BlkMask;
               off_d  = '0;
               if (LATENCY == 0) begin
                  state_d = StFetch;
               end else begin
                  state_d = StWait;
                  cnt_d   = CntLoad;
               end
            end
         end
         StWait: begin
            if (cnt_q == '0) begin
               state_d = StFetch;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StFetch: begin
            off_d = off_q + OffW'(1);
            if (off_q == LastOff) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         off_q   <= '0;
         base_q  <= '0;
         block_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         off_q   <= off_d;
         base_q  <= base_d;
         if (state_q == StFetch) begin
            block_q[off_q] <= rd_word;
         end
      end
   end

   assign blockOut   = block_q;
   assign blockReady = (state_q == StDone);
   assign busy       = (state_q != StIdle);

`ifdef BLOCK_MEM_REQ_COUNT_EN
   logic [13:0] read_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         read_cnt_q <= '0;
      end else if (state_q == StDone && read_cnt_q != 14'h3FFF) begin
         read_cnt_q <= read_cnt_q + 14'd1;
      end
   end

   assign readCount = read_cnt_q;
`endif

endmodule
